skid_slice: RTL and testbench

SKID_SLICE -- requirements
Module: skid_slice

---
 rtl/skid_slice.sv | 121 ++++++++++++
 tb/tb_skid_slice.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/skid_slice.sv
// skid_slice: two-entry register slice for a valid/ready stream.
// The upstream ready and the downstream valid both come straight from flops,
// so this slice breaks every combinational path in both directions.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   flush                 - synchronous discard of all held beats
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and payload (main reg)
//   count                 - number of held beats, 0..2
//
// state | meaning
// EMPTY | no beat held, main holds stale data
// ONE   | head beat in main, skid unused
// FULL  | head beat in main, next beat in skid, upstream stalled
module skid_slice #(
  parameter int unsigned          WIDTH = 32,
  parameter logic [WIDTH-1:0]     INIT  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign count     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move
        if (out_fire) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
    // Flush empties the slice but leaves the data registers untouched, so
    // out_data keeps showing the last head value.
    if (flush) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= INIT;
    end else if (load_main) begin
      main_q <= main_from_skid ? skid_q : in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= INIT;
    end else if (load_skid) begin
      skid_q <= in_data;
    end
  end

endmodule

// File: tb/tb_skid_slice.sv
// tb_skid_slice: directed and random stimulus for skid_slice, checked against
// a queue-based model of a two-deep FIFO with flush.
module tb_skid_slice;
  localparam int unsigned W = 32;
  localparam logic [W-1:0] INIT_V = 32'hDEAD_BEEF;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] head_val;
  logic [W-1:0] delivered[$];

  skid_slice #(.WIDTH(W), .INIT(INIT_V)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"},     W'(count),     W'(q.size()));
    chk({tag, ".out_valid"}, W'(out_valid), W'(q.size() != 0));
    chk({tag, ".in_ready"},  W'(in_ready),  W'(q.size() < 2));
    chk({tag, ".out_data"},  out_data,      head_val);
  endtask

  // Drive one cycle of inputs (called just after a negedge), advance the
  // model at the posedge, then compare at the following negedge.
  task automatic cycle(input logic iv, input logic [W-1:0] id,
                       input logic ordy, input logic fl, input string tag);
    bit m_in_fire, m_out_fire;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    m_in_fire  = iv && (q.size() < 2);
    m_out_fire = ordy && (q.size() > 0);
    if (out_valid && ordy) delivered.push_back(out_data);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (m_out_fire) void'(q.pop_front());
      if (m_in_fire) q.push_back(id);
    end
    if (q.size() > 0) head_val = q[0];
    @(negedge clk);
    chk_model(tag);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    head_val = INIT_V;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst.out_valid", W'(out_valid), '0);
    chk("rst.in_ready",  W'(in_ready),  W'(1));
    chk("rst.count",     W'(count),     '0);
    chk("rst.out_data",  out_data,      INIT_V);
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0, "rst_rel");
    cycle(1'b0, '0, 1'b1, 1'b0, "rst_rel2");

    // streaming 1..8 with out_ready high
    delivered.delete();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, W'(i), 1'b1, 1'b0, "stream");
      chk("stream.head", out_data, W'(i));
      chk("stream.cnt_le1", W'(count <= 2'd1), W'(1));
    end
    cycle(1'b0, '0, 1'b1, 1'b0, "stream_drain");
    chk("stream.n_out", W'(delivered.size()), W'(8));
    for (int i = 0; i < 8 && i < delivered.size(); i++)
      chk("stream.order", delivered[i], W'(i + 1));

    // backpressure
    delivered.delete();
    cycle(1'b1, 32'hA, 1'b0, 1'b0, "bp");
    cycle(1'b1, 32'hB, 1'b0, 1'b0, "bp");
    chk("bp.count2", W'(count), W'(2));
    chk("bp.in_ready0", W'(in_ready), '0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0, "bp_hold");
    chk("bp.hold_count", W'(count), W'(2));
    cycle(1'b1, 32'hC, 1'b1, 1'b0, "bp_drain");
    cycle(1'b1, 32'hC, 1'b1, 1'b0, "bp_drain");
    cycle(1'b0, '0, 1'b1, 1'b0, "bp_drain");
    cycle(1'b0, '0, 1'b1, 1'b0, "bp_drain");
    chk("bp.n_out", W'(delivered.size()), W'(3));
    if (delivered.size() == 3) begin
      chk("bp.out0", delivered[0], 32'hA);
      chk("bp.out1", delivered[1], 32'hB);
      chk("bp.out2", delivered[2], 32'hC);
    end

    // simultaneous in_fire and out_fire in ONE
    cycle(1'b1, 32'h5, 1'b0, 1'b0, "sim");
    chk("sim.one5", out_data, 32'h5);
    cycle(1'b1, 32'h6, 1'b1, 1'b0, "sim");
    chk("sim.count", W'(count), W'(1));
    chk("sim.data6", out_data, 32'h6);
    cycle(1'b0, '0, 1'b1, 1'b0, "sim_drain");

    // flush from FULL, then flush from ONE discarding an accepted beat
    delivered.delete();
    cycle(1'b1, 32'h1, 1'b0, 1'b0, "fl");
    cycle(1'b1, 32'h2, 1'b0, 1'b0, "fl");
    cycle(1'b1, 32'h3, 1'b0, 1'b1, "fl_full");
    chk("fl.count0", W'(count), '0);
    chk("fl.out_valid0", W'(out_valid), '0);
    chk("fl.in_ready1", W'(in_ready), W'(1));
    cycle(1'b1, 32'h4, 1'b0, 1'b0, "fl");
    cycle(1'b1, 32'h3, 1'b0, 1'b1, "fl_one");
    chk("fl.one_count0", W'(count), '0);
    cycle(1'b0, '0, 1'b1, 1'b0, "fl_after");
    cycle(1'b0, '0, 1'b1, 1'b0, "fl_after");
    chk("fl.nothing_out", W'(delivered.size()), '0);

    // mid-operation reset from FULL
    cycle(1'b1, 32'h7, 1'b0, 1'b0, "mr");
    cycle(1'b1, 32'h8, 1'b0, 1'b0, "mr");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr.count0", W'(count), '0);
    chk("mr.out_data_init", out_data, INIT_V);
    chk("mr.out_valid0", W'(out_valid), '0);
    chk("mr.in_ready1", W'(in_ready), W'(1));
    q.delete();
    head_val = INIT_V;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_model("mr_rel");
    cycle(1'b1, 32'h9, 1'b0, 1'b0, "mr_beat");
    chk("mr.data9", out_data, 32'h9);
    cycle(1'b0, '0, 1'b1, 1'b0, "mr_drain");

    // random phase against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), W'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
